// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with register file, load-use bubble and flush.
// Optional macro DEC_WB_BYPASS_EN forwards same-cycle write-back into operands.
module decode_stage #(
    parameter  int REG_WIDTH = 32,
    parameter  int REG_COUNT = 32,
    parameter  int PC_WIDTH  = 32,
    localparam int REG_BITS  = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [PC_WIDTH-1:0]  in_pc,
    input  logic                 flush,
    input  logic                 wb_en,
    input  logic [REG_BITS-1:0]  wb_rd,
    input  logic [REG_WIDTH-1:0] wb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_BITS-1:0]  out_rd,
    output logic [REG_BITS-1:0]  out_rs1,
    output logic [REG_BITS-1:0]  out_rs2,
    output logic [REG_WIDTH-1:0] out_rs1_data,
    output logic [REG_WIDTH-1:0] out_rs2_data,
    output logic [REG_WIDTH-1:0] out_imm,
    output logic [PC_WIDTH-1:0]  out_pc,
    output logic [6:0]           out_opcode,
    output logic [2:0]           out_funct3,
    output logic                 out_funct7b5,
    output logic                 out_is_load
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    logic [REG_WIDTH-1:0] rf [REG_COUNT];

    logic [6:0]          opc;
    logic [4:0]          f_rs1;
    logic [4:0]          f_rs2;
    logic [REG_BITS-1:0] rd_idx;
    logic [REG_BITS-1:0] rs1_idx;
    logic [REG_BITS-1:0] rs2_idx;

    assign opc     = in_instr[6:0];
    assign f_rs1   = in_instr[19:15];
    assign f_rs2   = in_instr[24:20];
    assign rd_idx  = REG_BITS'(in_instr[11:7]);
    assign rs1_idx = REG_BITS'(f_rs1);
    assign rs2_idx = REG_BITS'(f_rs2);

    logic is_i;
    logic is_s;
    logic is_b;
    logic is_u;
    logic is_j;
    logic is_r;

    always_comb begin
        is_i = (opc == OP_IMM) || (opc == OP_LOAD) || (opc == OP_JALR);
        is_s = (opc == OP_STORE);
        is_b = (opc == OP_BR);
        is_u = (opc == OP_LUI) || (opc == OP_AUIPC);
        is_j = (opc == OP_JAL);
        is_r = (opc == OP_REG);
    end

    logic [31:0]          imm32;
    logic [REG_WIDTH-1:0] imm;

    always_comb begin
        imm32 = '0;
        unique case (1'b1)
            is_i: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            is_s: imm32 = {{20{in_instr[31]}}, in_instr[31:25],
                           in_instr[11:7]};
            is_b: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
            is_u: imm32 = {in_instr[31:12], 12'b0};
            is_j: imm32 = {{11{in_instr[31]}}, in_instr[31],
                           in_instr[19:12], in_instr[20],
                           in_instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = REG_WIDTH'($signed(imm32));

    // Reads see the pre-write value; x0 and out-of-range indices read zero.
    logic                 rs1_ok;
    logic                 rs2_ok;
    logic [REG_WIDTH-1:0] rs1_rf;
    logic [REG_WIDTH-1:0] rs2_rf;

    always_comb begin
        rs1_ok = (f_rs1 != 5'd0) && (int'(f_rs1) < REG_COUNT);
        rs2_ok = (f_rs2 != 5'd0) && (int'(f_rs2) < REG_COUNT);
        rs1_rf = '0;
        rs2_rf = '0;
        if (rs1_ok) rs1_rf = rf[rs1_idx];
        if (rs2_ok) rs2_rf = rf[rs2_idx];
    end

    logic wb_we;
    assign wb_we = wb_en && (wb_rd != '0) && (int'(wb_rd) < REG_COUNT);

    logic [REG_WIDTH-1:0] rs1_src;
    logic [REG_WIDTH-1:0] rs2_src;

`ifdef DEC_WB_BYPASS_EN
    logic hold_hit1;
    logic hold_hit2;

    always_comb begin
        rs1_src = rs1_rf;
        rs2_src = rs2_rf;
        if (wb_we && rs1_ok && (wb_rd == rs1_idx)) rs1_src = wb_data;
        if (wb_we && rs2_ok && (wb_rd == rs2_idx)) rs2_src = wb_data;
    end

    assign hold_hit1 = wb_we && (wb_rd == out_rs1);
    assign hold_hit2 = wb_we && (wb_rd == out_rs2);
`else
    assign rs1_src = rs1_rf;
    assign rs2_src = rs2_rf;
`endif

    logic uses_rs1;
    logic uses_rs2;
    logic hazard;
    logic accept;
    logic drain;

    assign uses_rs1 = !(is_u || is_j);
    assign uses_rs2 = is_r || is_s || is_b;

    // Load in the output stage whose result the incoming instruction needs.
    assign hazard = out_valid && out_is_load && (out_rd != '0) &&
                    ((uses_rs1 && (out_rd == rs1_idx)) ||
                     (uses_rs2 && (out_rd == rs2_idx)));

    assign in_ready = !rst && !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) rf[i] <= '0;
        end else if (wb_we) begin
            rf[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_rd       <= '0;
            out_rs1      <= '0;
            out_rs2      <= '0;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            out_imm      <= '0;
            out_pc       <= '0;
            out_opcode   <= '0;
            out_funct3   <= '0;
            out_funct7b5 <= 1'b0;
            out_is_load  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_rd       <= rd_idx;
            out_rs1      <= rs1_idx;
            out_rs2      <= rs2_idx;
            out_rs1_data <= rs1_src;
            out_rs2_data <= rs2_src;
            out_imm      <= imm;
            out_pc       <= in_pc;
            out_opcode   <= opc;
            out_funct3   <= in_instr[14:12];
            out_funct7b5 <= in_instr[30];
            out_is_load  <= (opc == OP_LOAD);
        end else if (drain) begin
            out_valid <= 1'b0;
`ifdef DEC_WB_BYPASS_EN
        end else if (out_valid) begin
            if (hold_hit1) out_rs1_data <= wb_data;
            if (hold_hit2) out_rs2_data <= wb_data;
`endif
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: vector table, directed corner sequences and random
// stimulus against a behavioural model of the decode stage.
module tb_decode_stage;

`ifdef DEC_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [31:0] out_rs1_data;
    logic [31:0] out_rs2_data;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic        out_funct7b5;
    logic        out_is_load;

    decode_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_imm(out_imm), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_funct3(out_funct3),
        .out_funct7b5(out_funct7b5), .out_is_load(out_is_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_rf [32];
    bit          m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    logic [31:0] m_d1;
    logic [31:0] m_d2;
    bit          rdy_s;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        int v;
        v = 0;
        case (ins[6:0])
            7'b0010011, 7'b0000011, 7'b1100111:
                v = $signed(ins) >>> 20;
            7'b0100011:
                v = (($signed(ins) >>> 25) * 32) + int'(ins[11:7]);
            7'b1100011: begin
                v = int'(ins[31]) * 4096 + int'(ins[7]) * 2048 +
                    int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
                if (ins[31]) v -= 8192;
            end
            7'b0110111, 7'b0010111:
                v = int'(ins & 32'hFFFFF000);
            7'b1101111: begin
                v = int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * 4096 +
                    int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
                if (ins[31]) v -= (1 << 21);
            end
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic bit m_hazard(input logic [31:0] ins);
        logic [6:0] op;
        bit u1;
        bit u2;
        logic [4:0] lrd;
        op  = ins[6:0];
        u1  = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
        u2  = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
        lrd = m_instr[11:7];
        if (!m_valid || m_instr[6:0] != 7'b0000011 || lrd == 0) return 0;
        return (u1 && lrd == ins[19:15]) || (u2 && lrd == ins[24:20]);
    endfunction

    function automatic bit m_ready();
        return !rst && !flush && !m_hazard(in_instr) && (!m_valid || out_ready);
    endfunction

    function automatic logic [31:0] m_src(input logic [4:0] idx);
        if (idx == 0) return 0;
        if (BYP && wb_en && wb_rd == idx) return wb_data;
        return m_rf[idx];
    endfunction

    task automatic model_edge();
        bit acc;
        bit drn;
        logic [31:0] r1;
        logic [31:0] r2;
        acc = in_valid && m_ready();
        drn = m_valid && out_ready;
        r1  = m_src(in_instr[19:15]);
        r2  = m_src(in_instr[24:20]);
        if (rst) begin
            m_valid = 0;
            m_instr = 0;
            m_pc    = 0;
            m_d1    = 0;
            m_d2    = 0;
            for (int i = 0; i < 32; i++) m_rf[i] = 0;
            return;
        end
        if (flush) m_valid = 0;
        else if (acc) begin
            m_valid = 1;
            m_instr = in_instr;
            m_pc    = in_pc;
            m_d1    = r1;
            m_d2    = r2;
        end else if (drn) m_valid = 0;
        else if (m_valid && BYP && wb_en && wb_rd != 0) begin
            if (wb_rd == m_instr[19:15]) m_d1 = wb_data;
            if (wb_rd == m_instr[24:20]) m_d2 = wb_data;
        end
        if (wb_en && wb_rd != 0) m_rf[wb_rd] = wb_data;
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, m_valid);
        chk("out_pc", out_pc, m_pc);
        chk("out_rd", out_rd, m_instr[11:7]);
        chk("out_rs1", out_rs1, m_instr[19:15]);
        chk("out_rs2", out_rs2, m_instr[24:20]);
        chk("out_opcode", out_opcode, m_instr[6:0]);
        chk("out_funct3", out_funct3, m_instr[14:12]);
        chk("out_funct7b5", out_funct7b5, m_instr[30]);
        chk("out_is_load", out_is_load, m_instr[6:0] == 7'b0000011);
        chk("out_imm", out_imm, ref_imm(m_instr));
        chk("out_rs1_data", out_rs1_data, m_d1);
        chk("out_rs2_data", out_rs2_data, m_d2);
    endtask

    // Inputs are set at the falling edge before calling this.
    task automatic cycle();
        #1;
        rdy_s = in_ready;
        chk("in_ready", in_ready, m_ready());
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic present(input logic [31:0] ins, input logic [31:0] pc);
        in_valid = 1;
        in_instr = ins;
        in_pc    = pc;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        bit          ld;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{32'hFFF28313, 32'hFFFFFFFF, 5'd6,  5'd5, 5'd31, 1'b0};
        vecs[1] = '{32'h0020A423, 32'h00000008, 5'd8,  5'd1, 5'd2,  1'b0};
        vecs[2] = '{32'hFE208EE3, 32'hFFFFFFFC, 5'd29, 5'd1, 5'd2,  1'b0};
        vecs[3] = '{32'h12345537, 32'h12345000, 5'd10, 5'd8, 5'd3,  1'b0};
        vecs[4] = '{32'h001000EF, 32'h00000800, 5'd1,  5'd0, 5'd1,  1'b0};
        vecs[5] = '{32'h00238433, 32'h00000000, 5'd8,  5'd7, 5'd2,  1'b0};
        vecs[6] = '{32'h80000197, 32'h80000000, 5'd3,  5'd0, 5'd0,  1'b0};
        vecs[7] = '{32'h7FF102E7, 32'h000007FF, 5'd5,  5'd2, 5'd31, 1'b0};
        vecs[8] = '{32'hFF00A383, 32'hFFFFFFF0, 5'd7,  5'd1, 5'd16, 1'b1};

        m_valid = 0; m_instr = 0; m_pc = 0; m_d1 = 0; m_d2 = 0;
        for (int i = 0; i < 32; i++) m_rf[i] = 0;
        rst = 1; flush = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
        out_ready = 1;
        present(32'h00100093, 32'h10);

        for (int c = 0; c < 2; c++) begin
            cycle();
            chk("rst_in_ready", rdy_s, 0);
            chk("rst_out_valid", out_valid, 0);
        end
        rst = 0;

        for (int i = 1; i < 32; i++) begin
            logic [4:0] r;
            r = 5'(i);
            present({7'b0, r, r, 3'b0, 5'b0, 7'b0110011}, 32'(i * 4));
            cycle();
            chk("rf_zero_rs1", out_rs1_data, 0);
            chk("rf_zero_rs2", out_rs2_data, 0);
        end

        in_valid = 0; wb_en = 1; wb_rd = 5; wb_data = 32'h1234;
        cycle();
        wb_en = 0;
        present(32'hFFF28313, 32'h40);
        cycle();
        chk("t2_rs1_data", out_rs1_data, 32'h1234);
        chk("t2_imm", out_imm, 32'hFFFFFFFF);
        chk("t2_rd", out_rd, 6);
        chk("t2_pc", out_pc, 32'h40);

        for (int i = 0; i < 9; i++) begin
            present(vecs[i].instr, 32'h1000 + 32'(i * 4));
            cycle();
            chk("tbl_valid", out_valid, 1);
            chk("tbl_imm", out_imm, vecs[i].imm);
            chk("tbl_fields", {out_rd, out_rs1, out_rs2, out_is_load},
                {vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].ld});
            chk("tbl_pc", out_pc, 32'h1000 + 32'(i * 4));
        end

        present(32'h0000A383, 32'h80);
        cycle();
        chk("t3_load", out_is_load, 1);
        present(32'h00238433, 32'h84);
        cycle();
        chk("t3_stall_ready", rdy_s, 0);
        chk("t3_bubble", out_valid, 0);
        cycle();
        chk("t3_resume_ready", rdy_s, 1);
        chk("t3_add_valid", out_valid, 1);
        chk("t3_add_rd", out_rd, 8);

        present(32'h00100493, 32'h100);
        cycle();
        out_ready = 0;
        present(32'h00200513, 32'h104);
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("t4_hold_ready", rdy_s, 0);
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_pc", out_pc, 32'h100);
        end
        out_ready = 1;
        cycle();
        chk("t4_accept_ready", rdy_s, 1);
        chk("t4_next_pc", out_pc, 32'h104);

        flush = 1;
        present(32'h00300593, 32'h200);
        cycle();
        chk("t5_flushed", out_valid, 0);
        flush = 0;
        present(32'h00400613, 32'h204);
        cycle();
        chk("t5_resume", out_valid, 1);
        chk("t5_pc", out_pc, 32'h204);

        present(32'h00018233, 32'h300);
        wb_en = 1; wb_rd = 3; wb_data = 32'hAA;
        cycle();
        wb_en = 0;
        chk("t6_bypass", out_rs1_data, BYP ? 32'hAA : 32'h0);

        for (int c = 0; c < 600; c++) begin
            logic [31:0] ins;
            logic [6:0]  ops [10];
            ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                    7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                    7'b0110011, 7'b1111111};
            ins        = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 9)];
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            in_valid   = ($urandom_range(0, 3) != 0);
            in_instr   = ins;
            in_pc      = $urandom;
            out_ready  = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            wb_en      = $urandom_range(0, 1) == 1;
            wb_rd      = 5'($urandom_range(0, 7));
            wb_data    = $urandom;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
